// File: rtl/reduce_pkg.sv
// reduce_pkg: shared definitions for the reduction-table controller.
//   - flit field positions/widths (input word adds children above the
//     standard 73-bit flit)
//   - op encodings for the combine ALU
//   - FSM state type and reduction-table entry struct
//   - make_flit: packs the standard 73-bit flit layout
package reduce_pkg;

  localparam int PAYLOAD_LSB  = 0;
  localparam int PAYLOAD_W    = 32;
  localparam int OP_LSB       = 32;
  localparam int OP_W         = 4;
  localparam int ALG_LSB      = 36;
  localparam int ALG_W        = 2;
  localparam int TAG_LSB      = 38;
  localparam int TAG_W        = 8;
  localparam int CTX_LSB      = 46;
  localparam int CTX_W        = 8;
  localparam int SRC_LSB      = 54;
  localparam int SRC_W        = 9;
  localparam int DST_LSB      = 63;
  localparam int DST_W        = 9;
  localparam int VALID_BIT    = 72;
  localparam int CHILDREN_LSB = 73;
  localparam int CHILDREN_W   = 3;
  localparam int OUT_FLIT_W   = 73;
  localparam int IN_FLIT_W    = 76;
  localparam int REM_W        = 4;

  localparam logic [OP_W-1:0] OP_SUM = 4'd0;
  localparam logic [OP_W-1:0] OP_MAX = 4'd1;
  localparam logic [OP_W-1:0] OP_MIN = 4'd2;
  localparam logic [OP_W-1:0] OP_AND = 4'd3;
  localparam logic [OP_W-1:0] OP_OR  = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic                 entry_valid;
    logic [CTX_W-1:0]     context_id;
    logic [TAG_W-1:0]     tag;
    logic [OP_W-1:0]      op;
    logic [ALG_W-1:0]     algtype;
    logic [REM_W-1:0]     remaining;
    logic [PAYLOAD_W-1:0] acc;
  } entry_t;

  function automatic logic [OUT_FLIT_W-1:0] make_flit(
    input logic [DST_W-1:0]     dst,
    input logic [SRC_W-1:0]     src,
    input logic [CTX_W-1:0]     ctx,
    input logic [TAG_W-1:0]     tag,
    input logic [ALG_W-1:0]     alg,
    input logic [OP_W-1:0]      op,
    input logic [PAYLOAD_W-1:0] payload
  );
    return {1'b1, dst, src, ctx, tag, alg, op, payload};
  endfunction

endpackage

// File: rtl/reduce_alu.sv
// reduce_alu: combinational combine of two 32-bit operands.
//   a, b   : operands (a = running accumulator, b = incoming payload)
//   op     : 0 sum, 1 signed max, 2 signed min, 3 and, 4 or, 5 xor,
//            6..15 fall back to sum
//   result : combined value (sum wraps modulo 2^32)
module reduce_alu
  import reduce_pkg::*;
(
  input  logic [PAYLOAD_W-1:0] a,
  input  logic [PAYLOAD_W-1:0] b,
  input  logic [OP_W-1:0]      op,
  output logic [PAYLOAD_W-1:0] result
);

  always_comb begin
    result = a + b;
    case (op)
      OP_MAX:  result = ($signed(a) > $signed(b)) ? a : b;
      OP_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = a + b;
    endcase
  end

endmodule

// File: rtl/reduce_table_ctrl.sv
// reduce_table_ctrl: matches tree-tagged flits by (contextId, tag) against a
// small reduction table, combines payloads, and emits one reduced flit
// toward the parent once all contributions are in.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   in_flit        : {children, valid, dst, src, ctx, tag, algtype, op, payload}
//   in_valid/ready : input handshake
//   out_flit       : reduced 73-bit flit (dst = parent, src = own rank)
//   out_valid/ready: output handshake
//   busy           : some table entry is allocated
//   err_overflow   : sticky, a new pair was dropped on a full table
//
// Handshakes: a word transfers on any rising edge where valid and ready are
// both high. in_ready is high only in IDLE and never depends on in_valid.
// out_valid stays high with out_flit stable until out_ready is seen.
module reduce_table_ctrl
  import reduce_pkg::*;
#(
  parameter int         TableSize     = 4,
  parameter logic [2:0] rank_x        = 3'b0,
  parameter logic [2:0] rank_y        = 3'b0,
  parameter logic [2:0] rank_z        = 3'b0,
  parameter logic [2:0] parent_x      = 3'b0,
  parameter logic [2:0] parent_y      = 3'b0,
  parameter logic [2:0] parent_z      = 3'b0,
  parameter int         FlitWidth     = 73,
  parameter int         ChildrenWidth = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FlitWidth+ChildrenWidth-1:0] in_flit,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [FlitWidth-1:0]               out_flit,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               err_overflow
);

  localparam int IdxW = (TableSize > 1) ? $clog2(TableSize) : 1;
  localparam logic [DST_W-1:0] PARENT = {parent_x, parent_y, parent_z};
  localparam logic [SRC_W-1:0] RANK   = {rank_x, rank_y, rank_z};

  state_e                             state_q, state_d;
  logic [FlitWidth+ChildrenWidth-1:0] hold_q;
  entry_t                             tbl_q [TableSize];
  logic                               hit_q, free_q;
  logic [IdxW-1:0]                    hit_idx_q, free_idx_q;
  logic                               hit_c, free_c;
  logic [IdxW-1:0]                    hit_idx_c, free_idx_c;
  logic [FlitWidth-1:0]               out_flit_q;
  logic                               err_q;
  logic                               busy_c;

  logic [CTX_W-1:0]         h_ctx;
  logic [TAG_W-1:0]         h_tag;
  logic [ALG_W-1:0]         h_alg;
  logic [OP_W-1:0]          h_op;
  logic [PAYLOAD_W-1:0]     h_payload;
  logic [ChildrenWidth-1:0] h_children;
  entry_t                   hit_ent;
  logic [PAYLOAD_W-1:0]     alu_res;
  logic [REM_W-1:0]         rem_dec;
  logic                     emit_c;
  logic                     unused_hold;

  assign h_ctx      = hold_q[CTX_LSB +: CTX_W];
  assign h_tag      = hold_q[TAG_LSB +: TAG_W];
  assign h_alg      = hold_q[ALG_LSB +: ALG_W];
  assign h_op       = hold_q[OP_LSB +: OP_W];
  assign h_payload  = hold_q[PAYLOAD_LSB +: PAYLOAD_W];
  assign h_children = hold_q[FlitWidth +: ChildrenWidth];
  // Incoming dst/src/valid are not needed once the flit is captured.
  assign unused_hold = ^hold_q[VALID_BIT:SRC_LSB];

  assign hit_ent = tbl_q[hit_idx_q];
  assign rem_dec = hit_ent.remaining - 4'd1;
  // A match emits on its last contribution; a miss emits only for a leaf.
  assign emit_c  = hit_q ? (rem_dec == '0) : (h_children == '0);

  reduce_alu u_alu (
    .a      (hit_ent.acc),
    .b      (h_payload),
    .op     (hit_ent.op),
    .result (alu_res)
  );

  // Parallel key match plus lowest-index free slot (descending scan so the
  // lowest free index is the last one written).
  always_comb begin
    hit_c      = 1'b0;
    hit_idx_c  = '0;
    free_c     = 1'b0;
    free_idx_c = '0;
    busy_c     = 1'b0;
    for (int i = 0; i < TableSize; i++) begin
      busy_c = busy_c | tbl_q[i].entry_valid;
      if (tbl_q[i].entry_valid && tbl_q[i].context_id == h_ctx && tbl_q[i].tag == h_tag) begin
        hit_c     = 1'b1;
        hit_idx_c = IdxW'(i);
      end
    end
    for (int i = TableSize - 1; i >= 0; i--) begin
      if (!tbl_q[i].entry_valid) begin
        free_c     = 1'b1;
        free_idx_c = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid && in_flit[VALID_BIT]) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = emit_c ? ST_EMIT : ST_IDLE;
      ST_EMIT:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_q     <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      free_q     <= 1'b0;
      free_idx_q <= '0;
      out_flit_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < TableSize; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (in_valid) hold_q <= in_flit;
        ST_LOOKUP: begin
          hit_q      <= hit_c;
          hit_idx_q  <= hit_idx_c;
          free_q     <= free_c;
          free_idx_q <= free_idx_c;
        end
        ST_UPDATE: begin
          if (hit_q) begin
            tbl_q[hit_idx_q].acc       <= alu_res;
            tbl_q[hit_idx_q].remaining <= rem_dec;
            if (rem_dec == '0) begin
              tbl_q[hit_idx_q].entry_valid <= 1'b0;
              out_flit_q <= make_flit(PARENT, RANK, hit_ent.context_id, hit_ent.tag,
                                      hit_ent.algtype, hit_ent.op, alu_res);
            end
          end else if (h_children == '0) begin
            out_flit_q <= make_flit(PARENT, RANK, h_ctx, h_tag, h_alg, h_op, h_payload);
          end else if (free_q) begin
            tbl_q[free_idx_q] <= '{entry_valid: 1'b1, context_id: h_ctx, tag: h_tag,
                                   op: h_op, algtype: h_alg,
                                   remaining: REM_W'(h_children), acc: h_payload};
          end else begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_EMIT);
  assign out_flit     = out_flit_q;
  assign busy         = busy_c;
  assign err_overflow = err_q;

endmodule

// File: doc/reduce_table_ctrl.md
# reduce_table_ctrl

Reduction-table controller for the in-network MPI reduce path. It accepts tree-tagged flits from the instruction stage, each carrying a 3-bit children count. It matches them by (contextId, tag) against a small reduction table and combines payloads with the flit's op. Once a node's own contribution and all its children's contributions have arrived, it emits one reduced 73-bit flit toward the parent.

## Interface
Parameters:
- `TableSize`, 4: number of reduction-table entries (power of 2, 2..16).
- `rank_x/rank_y/rank_z`, 3'b0: own coordinates, written to the src field of emitted flits.
- `parent_x/parent_y/parent_z`, 3'b0: parent coordinates, written to the dst field of emitted flits.
- `FlitWidth`, 73: output flit width.
- `ChildrenWidth`, 3: children field width.

Ports:
- `clk`: input, 1. Single clock.
- `rst`: input, 1. Reset is synchronous and active-high.
- `in_flit`: input, 76. Input word, laid out as children[75:73], valid[72], dst[71:63], src[62:54], contextId[53:46], tag[45:38], algtype[37:36], op[35:32], payload[31:0].
- `in_valid`: input, 1. Input word present.
- `in_ready`: output, 1. Controller accepts a word this cycle.
- `out_flit`: output, 73. Reduced flit in the standard 73-bit layout.
- `out_valid`: output, 1. `out_flit` is valid.
- `out_ready`: input, 1. Downstream accepts.
- `busy`: output, 1. At least one table entry is allocated.
- `err_overflow`: output, 1. Sticky; set when a flit is dropped because the table is full.

## Operation
- Table entry fields: entry_valid, contextId, tag, op, algtype, remaining (4 bits), acc (32 bits).
- FSM states: IDLE, LOOKUP, UPDATE, EMIT.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: capture `in_flit` into the holding register and go to LOOKUP.
  - A captured flit with valid bit = 0 is discarded and the FSM stays in IDLE.
- LOOKUP:
  - Compare {contextId, tag} in parallel against all valid entries.
  - Also find the lowest-index free entry.
  - Always go to UPDATE.
- UPDATE, match case:
  - acc ← combine(acc, payload, entry.op); remaining ← remaining − 1.
  - If the new remaining is 0: load the output register with acc, free the entry, go to EMIT. Otherwise go to IDLE.
- UPDATE, no match, children = 0 (leaf):
  - Load the output register with the payload directly and go to EMIT. No entry is allocated.
- UPDATE, no match, children > 0, free entry exists:
  - Allocate the entry with acc = payload and remaining = children. The first flit counts as the node's own contribution.
  - Go to IDLE.
- UPDATE, no match, table full:
  - Drop the flit, set `err_overflow`, go to IDLE.
- EMIT:
  - `out_valid` = 1. `out_flit` holds stable until `out_ready`; on `out_ready` go to IDLE.
- Op encoding (4 bits):
  - 0 = sum, modulo 2^32 wraparound, no saturation.
  - 1 = signed max; 2 = signed min.
  - 3 = and; 4 = or; 5 = xor.
  - 6–15 = sum.
- Output flit contents:
  - valid = 1.
  - dst = parent coordinates; src = own coordinates.
  - contextId, tag, algtype, op copied from the entry (leaf case: from the input flit).
  - payload = result.
- The children field of a matching (non-first) flit is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready` = 1 in the first cycle after reset.
  - `out_valid` = 0; `out_flit` = 0.
  - All entries invalid.
  - `busy` = 0; `err_overflow` = 0.
- Throughput: one flit per 3 cycles at most; 4 cycles when an emit occurs and `out_ready` is already high.
- Latency: with acceptance at edge 0, `out_valid` is high after edge 2 (leaf case or final contribution).
- `in_ready` is low in LOOKUP, UPDATE and EMIT. No input is accepted while an output is pending, so results never reorder.
- `busy` is registered and updates at the UPDATE edge.
- Reset asserted mid-operation: the next edge clears the FSM, the table and the output register. A pending `out_valid` drops without waiting for the handshake.

## Structure
- Package `reduce_pkg` holds:
  - flit field position and width constants (payload through children);
  - op encodings;
  - the FSM state typedef;
  - the table entry struct typedef.
- Sub-module `reduce_alu`: purely combinational (a, b, op) → result. It is instantiated once in the UPDATE path.

## Test plan
- Leaf: children = 0, op = 0, payload 5 → one flit, payload 5, dst = parent, 2 edges after acceptance. Table stays empty.
- Three contributions, ctx 1, tag 2, op 0:
  - Inputs: payload 3 (children = 2), then 4, then 10.
  - Required: exactly one flit with payload 17; entry freed; `busy` = 0.
- Signed ops:
  - op = 1 with payloads −1, 7 (children = 1) → 7.
  - op = 2 with the same payloads → 0xFFFFFFFF.
  - op = 5 with 0xF0F0, 0x0FF0 → 0xFF00.
- Overflow, TableSize = 4: open 4 distinct (ctx, tag) pairs with children = 1, then send a 5th new pair → dropped, `err_overflow` = 1. Completing the first 4 yields 4 flits.
- Backpressure: hold `out_ready` = 0 for 10 cycles during EMIT → `out_flit` stays stable, `in_ready` = 0. Release → a single handshake, then IDLE.
- Reset during EMIT, plus sum wraparound:
  - Assert `rst` during EMIT → `out_valid` = 0 the next cycle, table cleared.
  - Sum 0xFFFFFFFF + 2 → 1.
